// File: rtl/zet_ng_wb_ext_arbiter.sv
// Two-master Wishbone B3 arbiter for the external-memory port.
// m0 = Zet CPU, m1 = OSD MAM debug. Whole cyc tenures are granted round-robin,
// with at least one IDLE cycle between tenures. A per-access watchdog answers
// a stalled strobe with err so a dead slave cannot hang the debug path.
//
// Handshake: Wishbone B3 classic/burst. A beat completes on any cycle where the
// owner's stb is high and one of ack/err/rty is returned; the owner holds
// ownership for as long as its cyc stays high, and releases in the first cycle
// its cyc is low.
module zet_ng_wb_ext_arbiter #(
  parameter int ADDR_WIDTH = 27,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [31:0]           m0_dat_i,
  input  logic [3:0]            m0_sel_i,
  input  logic                  m0_we_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic [31:0]           m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [31:0]           m1_dat_i,
  input  logic [3:0]            m1_sel_i,
  input  logic                  m1_we_i,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic [31:0]           m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [31:0]           s_dat_o,
  output logic [3:0]            s_sel_o,
  output logic                  s_we_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  output logic [1:0]            grant_o,
  output logic                  timeout_o
);

  // A disabled watchdog still keeps a 1-bit counter so no zero-width vector exists.
  localparam int WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic            owner, owner_next;
  logic            last, last_next;
  logic [WD_W-1:0] wd_cnt, wd_next;

  logic                  busy, resp, fire;
  logic                  own_cyc, own_stb;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [31:0]           own_dat;
  logic [3:0]            own_sel;
  logic                  own_we;
  logic [2:0]            own_cti;
  logic [1:0]            own_bte;

  assign busy = (state == BUSY);
  assign resp = s_ack_i | s_err_i | s_rty_i;

  // Select the current owner's request lines.
  always_comb begin
    own_adr = owner ? m1_adr_i : m0_adr_i;
    own_dat = owner ? m1_dat_i : m0_dat_i;
    own_sel = owner ? m1_sel_i : m0_sel_i;
    own_we  = owner ? m1_we_i  : m0_we_i;
    own_cyc = owner ? m1_cyc_i : m0_cyc_i;
    own_stb = owner ? m1_stb_i : m0_stb_i;
    own_cti = owner ? m1_cti_i : m0_cti_i;
    own_bte = owner ? m1_bte_i : m0_bte_i;
  end

  // Watchdog fires only on an unanswered strobe; a same-cycle response wins.
  assign fire = (TIMEOUT != 0) && busy && own_cyc && own_stb && !resp &&
                (wd_cnt == WD_MAX);

  // Bus muxing and response routing; everything is quiet outside BUSY.
  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_cti_o   = '0;
    s_bte_o   = '0;
    m0_dat_o  = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_rty_o  = 1'b0;
    m1_dat_o  = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_rty_o  = 1'b0;
    grant_o   = 2'b00;
    timeout_o = fire;
    if (busy) begin
      s_adr_o = own_adr;
      s_dat_o = own_dat;
      s_sel_o = own_sel;
      s_we_o  = own_we;
      s_cyc_o = own_cyc & ~fire;
      s_stb_o = own_stb & ~fire;
      s_cti_o = own_cti;
      s_bte_o = own_bte;
      grant_o = {owner, ~owner};
      if (owner) begin
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | fire;
        m1_rty_o = s_rty_i;
      end else begin
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | fire;
        m0_rty_o = s_rty_i;
      end
    end
  end

  // Next-state logic: arbitration in IDLE, release and watchdog in BUSY.
  always_comb begin
    state_next = state;
    owner_next = owner;
    last_next  = last;
    wd_next    = wd_cnt;
    case (state)
      IDLE: begin
        wd_next = '0;
        if (m0_cyc_i && m1_cyc_i) begin
          owner_next = ~last;
          state_next = BUSY;
        end else if (m0_cyc_i) begin
          owner_next = 1'b0;
          state_next = BUSY;
        end else if (m1_cyc_i) begin
          owner_next = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_next = IDLE;
          last_next  = owner;
          wd_next    = '0;
        end else if ((TIMEOUT == 0) || fire || !own_stb || resp) begin
          wd_next = '0;
        end else begin
          wd_next = wd_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers; last resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      wd_cnt <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      last   <= last_next;
      wd_cnt <= wd_next;
    end
  end

endmodule

// File: tb/tb_zet_ng_wb_ext_arbiter.sv
// Directed bench for zet_ng_wb_ext_arbiter. Inputs change on the falling edge
// and outputs are sampled 1 ns later. A second instance with the watchdog
// disabled shares all inputs.
module tb_zet_ng_wb_ext_arbiter;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] m0_adr = '0, m1_adr = '0;
  logic [31:0]   m0_dat = '0, m1_dat = '0;
  logic [3:0]    m0_sel = '0, m1_sel = '0;
  logic          m0_we = 1'b0, m0_cyc = 1'b0, m0_stb = 1'b0;
  logic          m1_we = 1'b0, m1_cyc = 1'b0, m1_stb = 1'b0;
  logic [2:0]    m0_cti = '0, m1_cti = '0;
  logic [1:0]    m0_bte = '0, m1_bte = '0;
  logic [31:0]   s_dat_in = '0;
  logic          s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

  logic [31:0]   m0_rd, m1_rd;
  logic          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [AW-1:0] s_adr;
  logic [31:0]   s_dat;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc, s_stb;
  logic [2:0]    s_cti;
  logic [1:0]    s_bte;
  logic [1:0]    grant;
  logic          timeout;

  logic [31:0]   z_m0_rd, z_m1_rd;
  logic          z_m0_ack, z_m0_err, z_m0_rty, z_m1_ack, z_m1_err, z_m1_rty;
  logic [AW-1:0] z_s_adr;
  logic [31:0]   z_s_dat;
  logic [3:0]    z_s_sel;
  logic          z_s_we, z_s_cyc, z_s_stb;
  logic [2:0]    z_s_cti;
  logic [1:0]    z_s_bte;
  logic [1:0]    z_grant;
  logic          z_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  zet_ng_wb_ext_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_dat_o(m0_rd), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_dat_o(m1_rd), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_dat_in), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant), .timeout_o(timeout)
  );

  zet_ng_wb_ext_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(0)) dut_nowd (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
    .m0_dat_o(z_m0_rd), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err), .m0_rty_o(z_m0_rty),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
    .m1_dat_o(z_m1_rd), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err), .m1_rty_o(z_m1_rty),
    .s_adr_o(z_s_adr), .s_dat_o(z_s_dat), .s_sel_o(z_s_sel), .s_we_o(z_s_we),
    .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb), .s_cti_o(z_s_cti), .s_bte_o(z_s_bte),
    .s_dat_i(s_dat_in), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(z_grant), .timeout_o(z_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic set_m0(input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat;
    m0_cti = cti; m0_sel = 4'hf; m0_bte = 2'b00;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat;
    m1_cti = cti; m1_sel = 4'hf; m1_bte = 2'b00;
  endtask

  task automatic reset_dut();
    next_cycle();
    rst = 1'b1;
    set_m0(0, 0, 0, '0, '0, 3'b000);
    set_m1(0, 0, 0, '0, '0, 3'b000);
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat_in = '0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  logic [1:0] exp_g;
  logic       early_err, z_err;

  initial begin
    // Reset state
    reset_dut();
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_s_stb", s_stb, 1'b0);
    check("rst_s_adr", s_adr, '0);
    check("rst_m0_ack", m0_ack, 1'b0);
    check("rst_m1_err", m1_err, 1'b0);
    check("rst_timeout", timeout, 1'b0);

    // Single m0 read of 0x100, three wait states, then ack with data
    next_cycle(); set_m0(1, 1, 0, 27'h100, '0, 3'b000); #1;
    check("rd_arb_lat_grant", grant, 2'b00);
    check("rd_arb_lat_cyc", s_cyc, 1'b0);
    for (int w = 0; w < 3; w++) begin
      next_cycle(); #1;
      check("rd_grant", grant, 2'b01);
      check("rd_s_cyc", s_cyc, 1'b1);
      check("rd_s_adr", s_adr, 27'h100);
      check("rd_wait_ack", m0_ack, 1'b0);
      check("rd_m1_quiet", {m1_rd, m1_ack, m1_err, m1_rty}, '0);
    end
    next_cycle(); s_ack = 1'b1; s_dat_in = 32'hdeadbeef; #1;
    check("rd_ack", m0_ack, 1'b1);
    check("rd_data", m0_rd, 32'hdeadbeef);
    check("rd_m1_quiet_ack", {m1_rd, m1_ack, m1_err, m1_rty}, '0);
    next_cycle(); s_ack = 1'b0; s_dat_in = '0; set_m0(0, 0, 0, '0, '0, 3'b000); #1;
    check("rd_release_cyc", s_cyc, 1'b0);
    next_cycle(); #1;
    check("rd_idle_grant", grant, 2'b00);

    // Simultaneous requests after reset: m0 first, then m1's write
    reset_dut();
    set_m0(1, 1, 0, 27'h40, '0, 3'b000);
    set_m1(1, 1, 1, 27'h2000, 32'h12345678, 3'b000);
    #1;
    check("sim_idle", grant, 2'b00);
    next_cycle(); s_ack = 1'b1; #1;
    check("sim_first_grant", grant, 2'b01);
    check("sim_first_adr", s_adr, 27'h40);
    check("sim_m0_ack", m0_ack, 1'b1);
    check("sim_m1_no_ack", m1_ack, 1'b0);
    next_cycle(); s_ack = 1'b0; set_m0(0, 0, 0, '0, '0, 3'b000); #1;
    check("sim_release_cyc", s_cyc, 1'b0);
    next_cycle(); #1;
    check("sim_gap_idle", grant, 2'b00);
    next_cycle(); s_ack = 1'b1; #1;
    check("sim_second_grant", grant, 2'b10);
    check("sim_wr_adr", s_adr, 27'h2000);
    check("sim_wr_dat", s_dat, 32'h12345678);
    check("sim_wr_we", s_we, 1'b1);
    check("sim_wr_sel", s_sel, 4'hf);
    check("sim_m1_ack", m1_ack, 1'b1);
    check("sim_m0_no_ack", m0_ack, 1'b0);
    next_cycle(); s_ack = 1'b0; set_m1(0, 0, 0, '0, '0, 3'b000); #1;
    next_cycle(); #1;
    check("sim_end_idle", grant, 2'b00);

    // Burst hold: m1 4-beat incrementing burst while m0 keeps requesting
    next_cycle(); set_m1(1, 1, 0, 27'h300, '0, 3'b010); #1;
    check("bst_idle", grant, 2'b00);
    next_cycle(); set_m0(1, 1, 0, 27'h80, '0, 3'b000);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) next_cycle();
      m1_adr = 27'h300 + 27'(4 * b);
      m1_cti = (b == 3) ? 3'b111 : 3'b010;
      s_ack = 1'b1; s_dat_in = 32'hb000 + 32'(b);
      #1;
      check("bst_grant", grant, 2'b10);
      check("bst_cti", s_cti, (b == 3) ? 3'b111 : 3'b010);
      check("bst_adr", s_adr, 27'h300 + 27'(4 * b));
      check("bst_m1_ack", m1_ack, 1'b1);
      check("bst_m1_dat", m1_rd, 32'hb000 + 32'(b));
      check("bst_m0_no_ack", m0_ack, 1'b0);
    end
    next_cycle(); s_ack = 1'b0; s_dat_in = '0; set_m1(0, 0, 0, '0, '0, 3'b000); #1;
    check("bst_release_grant", grant, 2'b10);
    check("bst_release_cyc", s_cyc, 1'b0);
    next_cycle(); #1;
    check("bst_gap_idle", grant, 2'b00);
    next_cycle(); #1;
    check("bst_m0_granted", grant, 2'b01);
    check("bst_m0_adr", s_adr, 27'h80);
    next_cycle(); set_m0(0, 0, 0, '0, '0, 3'b000); #1;
    next_cycle(); #1;

    // Round-robin: both request continuously for 8 tenures
    reset_dut();
    set_m0(1, 1, 0, 27'h10, '0, 3'b000);
    set_m1(1, 1, 0, 27'h20, '0, 3'b000);
    for (int t = 0; t < 8; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      if (t > 0) begin
        next_cycle();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      end
      #1;
      check("rr_idle", grant, 2'b00);
      next_cycle(); s_ack = 1'b1; #1;
      check("rr_grant", grant, exp_g);
      check("rr_adr", s_adr, (exp_g == 2'b01) ? 27'h10 : 27'h20);
      next_cycle(); s_ack = 1'b0;
      if (exp_g == 2'b01) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      else begin m1_cyc = 1'b0; m1_stb = 1'b0; end
      #1;
      check("rr_release_cyc", s_cyc, 1'b0);
    end
    next_cycle(); set_m0(0, 0, 0, '0, '0, 3'b000); set_m1(0, 0, 0, '0, '0, 3'b000); #1;
    check("rr_end_idle", grant, 2'b00);

    // Watchdog (TIMEOUT=16) and disabled watchdog (TIMEOUT=0)
    reset_dut();
    set_m0(1, 1, 0, 27'h500, '0, 3'b000);
    early_err = 1'b0;
    z_err = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      next_cycle(); s_ack = (k == 34); #1;
      z_err = z_err | z_m0_err | z_timeout;
      if (k == 17) begin
        check("wd_fire_err", m0_err, 1'b1);
        check("wd_fire_pulse", timeout, 1'b1);
        check("wd_fire_stb", s_stb, 1'b0);
        check("wd_fire_cyc", s_cyc, 1'b0);
        check("wd_fire_grant", grant, 2'b01);
        check("wd_off_stb", z_s_stb, 1'b1);
      end else if (k == 34) begin
        check("wd_ack_wins_ack", m0_ack, 1'b1);
        check("wd_ack_wins_err", m0_err, 1'b0);
        check("wd_ack_wins_pulse", timeout, 1'b0);
      end else begin
        early_err = early_err | m0_err | timeout;
        if (k == 18) check("wd_after_fire_stb", s_stb, 1'b1);
      end
    end
    check("wd_no_spurious_err", early_err, 1'b0);
    check("wd_disabled_no_err", z_err, 1'b0);
    next_cycle(); s_ack = 1'b0; set_m0(0, 0, 0, '0, '0, 3'b000); #1;

    // Reset mid-burst on m1's second beat
    next_cycle(); set_m1(1, 1, 0, 27'h400, '0, 3'b010); #1;
    check("rmb_idle", grant, 2'b00);
    next_cycle(); s_ack = 1'b1; s_dat_in = 32'h11; #1;
    check("rmb_beat0_grant", grant, 2'b10);
    next_cycle(); m1_adr = 27'h404; s_dat_in = 32'h22; rst = 1'b1; #1;
    check("rmb_beat1_ack", m1_ack, 1'b1);
    next_cycle(); rst = 1'b0; set_m0(1, 1, 0, 27'h600, '0, 3'b000); #1;
    check("rmb_grant", grant, 2'b00);
    check("rmb_s_cyc", s_cyc, 1'b0);
    check("rmb_s_stb", s_stb, 1'b0);
    check("rmb_s_adr", s_adr, '0);
    check("rmb_s_cti", s_cti, 3'b000);
    check("rmb_m1_resp", {m1_rd, m1_ack, m1_err, m1_rty}, '0);
    check("rmb_m0_resp", {m0_rd, m0_ack, m0_err, m0_rty}, '0);
    next_cycle(); s_ack = 1'b0; s_dat_in = '0; #1;
    check("rmb_tie_m0", grant, 2'b01);
    check("rmb_tie_adr", s_adr, 27'h600);
    next_cycle(); set_m0(0, 0, 0, '0, '0, 3'b000); set_m1(0, 0, 0, '0, '0, 3'b000); #1;
    next_cycle(); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
